serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, meaning operand width in bytes (legal 1..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin one operation.
REQ-005 SHALL have port a  input  8*NBYTES  operand A.
REQ-006 SHALL have port b  input  8*NBYTES  operand B.
REQ-007 SHALL have port cin  input  1  carry-in to byte 0.
REQ-008 SHALL have port sub  input  1  subtract request (ignored unless SUB_EN is defined).
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port sum  output  8*NBYTES  result.
REQ-012 SHALL have port cout  output  1  carry out of the top byte.

Function
REQ-013 SHALL instantiate exactly one hybrid_adder (8-bit, two cascaded 4-bit CLA stages) and time-share it across all bytes, LSB byte first.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE or DONE with start=1 at an edge: SHALL latch a, b, sub, and the carry register (cin, or 1 when subtracting), clear byte index to 0, and go to RUN.
REQ-016 DONE with start=0: SHALL go to IDLE at the next edge.
REQ-017 RUN, each edge: SHALL add latched byte[idx] of A and B plus the carry register, write the adder sum into sum[8*idx+7:8*idx], load the adder cout into the carry register, and increment idx.
REQ-018 RUN at idx=NBYTES-1: SHALL load cout from the adder carry-out, assert done, and go to DONE.
REQ-019 Latency: with start sampled at edge k, done SHALL be high exactly in the cycle following edge k+NBYTES, for one cycle only.
REQ-020 busy SHALL be high exactly while the state is RUN.
REQ-021 start while in RUN SHALL be ignored; operands and result SHALL be unaffected.
REQ-022 sum and cout SHALL be valid from the done cycle and held until the next accepted start; intermediate sum bits are don't-care while busy.
REQ-023 Input changes on a, b, cin, sub after the accepting edge SHALL NOT affect the result.
REQ-024 NBYTES=1: SHALL complete with done one cycle after the accepting edge.
REQ-025 Carry SHALL wrap silently: result is (A+B+cin) mod 2^(8*NBYTES), with cout as bit 8*NBYTES.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, cout=0, idx=0, and carry register 0, regardless of state.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse; start asserted together with rst SHALL be ignored.

Configuration
REQ-028 Macro SERIAL_ADD_CTRL_SUB_EN: when defined, sub=1 at acceptance SHALL latch ~b and force the initial carry to 1 (cin ignored), giving A-B with cout=1 meaning no borrow.
REQ-029 Without SERIAL_ADD_CTRL_SUB_EN, sub SHALL be ignored and only addition is performed; port list is unchanged.

Verification (NBYTES=4)
REQ-030 A=0x12345678, B=0x9ABCDEF0, cin=0, start at edge 0 -> done pulse after edge 4, sum=0xACF13568, cout=0, busy high for 4 cycles.
REQ-031 A=0xFFFFFFFF, B=0x00000001, cin=0 -> sum=0x00000000, cout=1 (full carry ripple across all bytes).
REQ-032 start re-pulsed at edge 2 during RUN with new operands -> ignored; first result and done timing are unchanged; start in the DONE cycle -> a new operation is accepted back-to-back.
REQ-033 rst=1 at edge 2 of a running operation -> IDLE, all outputs 0, no done pulse; a fresh start afterwards completes normally.
REQ-034 With SUB_EN: A=0x00000005, B=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0; without SUB_EN, the same stimulus -> sum=0x0000000C, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: byte-serial adder controller. One 8-bit hybrid adder
// (two cascaded 4-bit CLA stages) is time-shared over NBYTES operand
// bytes, LSB byte first, one byte per clock.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   begin an operation (honoured in IDLE or DONE only)
//   a, b   in   operands, 8*NBYTES bits, latched at acceptance
//   cin    in   carry into byte 0
//   sub    in   subtract request (used only with SERIAL_ADD_CTRL_SUB_EN)
//   busy   out  high while the byte loop is running
//   done   out  one-cycle completion pulse
//   sum    out  result, valid from done until the next accepted start
//   cout   out  carry out of the top byte
//
// Build option: define SERIAL_ADD_CTRL_SUB_EN to enable A-B when sub=1
// (b is inverted and the initial carry forced to 1; cout=1 means no borrow).

// 4-bit carry-lookahead stage with fully expanded carries.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum_c,
  output logic       cout_c
);
  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout_c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum_c = p ^ c;
endmodule

// 8-bit adder: two CLA nibbles with the carry rippled between them.
module hybrid_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum_c,
  output logic       cout_c
);
  logic mid_c;

  cla4 u_lo (
    .a      (a[3:0]),
    .b      (b[3:0]),
    .cin    (cin),
    .sum_c  (sum_c[3:0]),
    .cout_c (mid_c)
  );

  cla4 u_hi (
    .a      (a[7:4]),
    .b      (b[7:4]),
    .cin    (mid_c),
    .sum_c  (sum_c[7:4]),
    .cout_c (cout_c)
  );
endmodule

module serial_add_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout
);
  localparam int unsigned W     = 8 * NBYTES;
  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [W-1:0] op_b_c;
  logic         op_cin_c;
  logic [7:0]   byte_a_c;
  logic [7:0]   byte_b_c;
  logic [7:0]   add_sum_c;
  logic         add_cout_c;

  // Operand conditioning applied once, at acceptance.
`ifdef SERIAL_ADD_CTRL_SUB_EN
  assign op_b_c   = sub ? ~b : b;
  assign op_cin_c = sub | cin;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign op_b_c     = b;
  assign op_cin_c   = cin;
`endif

  // Select the current byte of each latched operand.
  always_comb begin
    byte_a_c = '0;
    byte_b_c = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        byte_a_c = a_q[8*i +: 8];
        byte_b_c = b_q[8*i +: 8];
      end
    end
  end

  hybrid_adder u_adder (
    .a      (byte_a_c),
    .b      (byte_b_c),
    .cin    (carry_q),
    .sum_c  (add_sum_c),
    .cout_c (add_cout_c)
  );

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = op_b_c;
          carry_d = op_cin_c;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[8*i +: 8] = add_sum_c;
          end
        end
        carry_d = add_cout_c;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_cout_c;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          busy_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (NBYTES=4): the stimulus thread
// pushes expected results, a negedge monitor pops them on each done pulse.
module tb_serial_add_ctrl;
  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    int           cyc;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Monitor: compare each done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (done_prev) chk("done_single_cycle", 64'(done), 64'd0);
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("sum_op%0d", e.id),  64'(sum),  64'(e.sum));
        chk($sformatf("cout_op%0d", e.id), 64'(cout), 64'(e.cout));
        chk($sformatf("done_cycle_op%0d", e.id), 64'(cyc), 64'(e.cyc));
      end
    end
    done_prev = done;
  end

  // Drive an operation at a negedge; returns at the negedge after acceptance
  // with the inputs scrambled so late input changes would show up.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic sv,
                       input logic [W-1:0] es, input logic ec,
                       input int id, input bit push);
    a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (push) exp_q.push_back('{es, ec, cyc + int'(NB), id});
    start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // Wait (bounded) for done, counting busy cycles on the way.
  task automatic wait_done(input int id, input int exp_busy);
    int bc   = 0;
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
    chk($sformatf("done_seen_op%0d", id), 64'(seen), 64'd1);
    chk($sformatf("busy_cycles_op%0d", id), 64'(bc), 64'(exp_busy));
  endtask

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv,
                        input logic [W-1:0] es, input logic ec, input int id);
    issue(av, bv, cv, sv, es, ec, id, 1'b1);
    wait_done(id, int'(NB));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sum",  64'(sum),  64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 2);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 3);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 4);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 5);

    // Start re-pulsed mid-run is ignored, then a back-to-back start in DONE.
    issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 6, 1'b1);
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, int'(NB) - 2);
    issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 7, 1'b1);
    wait_done(7, int'(NB));
    @(negedge clk);

    // Reset two edges into a run aborts it without a done pulse.
    issue(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, '0, 1'b0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum",  64'(sum),  64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 1'b0, 32'hDFD1_0456, 1'b0, 8);

    // Start together with reset is ignored.
    rst = 1'b1; start = 1'b1; a = 32'h0000_0001; b = 32'h0000_0001;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("rst_start_idle", 64'(busy), 64'd0);

`ifdef SERIAL_ADD_CTRL_SUB_EN
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 9);
`else
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 9);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
